aeolus_mem_arbiter: RTL and testbench

Two-requester arbiter that shares the Aeolus CPU's single-port program/data RAM between the instruction-fetch unit and the load/store unit. It sits between the CPU core and the RAM, below the top level. It issues at most one memory access per cycle with round-robin fairness on conflict. It routes each read result back to the requester that issued it.

---
 rtl/aeolus_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 28 ++
 rtl/aeolus_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_aeolus_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aeolus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aeolus_pkg
// Description : Shared definitions for the Aeolus memory arbiter slice:
//               default bus widths, read-owner encoding and grant-history
//               encoding used by the round-robin picker.
// Revision    : 1.0 - initial release
// ============================================================================
package aeolus_pkg;

    localparam int AEOLUS_ADDR_W = 8;
    localparam int AEOLUS_DATA_W = 8;

    // Which requester (if any) owns the read result returning next cycle.
    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_IF   = 2'd1,
        OWNER_DATA = 2'd2
    } owner_e;

    // Encoding of the last-granted-master history bit.
    localparam logic c_GNT_IF   = 1'b0;
    localparam logic c_GNT_DATA = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Combinational two-way round-robin picker. Bit 0 is the
//               instruction-fetch master, bit 1 the data master. On a
//               conflict the master that was not granted last wins.
// Ports       : effReq[1:0] - effective requests (already masked)
//               lastGnt     - last granted master (c_GNT_IF / c_GNT_DATA)
//               win[1:0]    - one-hot winner, zero when no request
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import aeolus_pkg::*;
(
    input  logic [1:0] effReq,
    input  logic       lastGnt,
    output logic [1:0] win
);

    always_comb begin
        win = effReq;
        if (effReq == 2'b11) begin
            win = (lastGnt == c_GNT_DATA) ? 2'b01 : 2'b10;
        end
    end

endmodule
`default_nettype wire

// File: rtl/aeolus_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : aeolus_mem_arbiter
// Description : Shares the single-port program/data RAM between the
//               instruction-fetch (IF) and load/store (data) units. One
//               access per cycle, round-robin on conflict, read results
//               routed back to the issuing master.
// Ports       : boardCLK, reset (async, active high)
//               ifReq/ifAddr        -> ifGnt/ifValid/ifRdata   fetch port
//               dReq/dWe/dAddr/dWdata -> dGnt/dValid/dRdata    data port
//               memEn/memWe/memAddr/memWdata, memRdata         RAM port
//               conflictCount       conflict statistics (optional)
// Config      : define AEOLUS_ARB_STATS_EN to add the saturating
//               conflictCount port and counter.
// Revision    : 1.0 - initial release
// ============================================================================
module aeolus_mem_arbiter
    import aeolus_pkg::*;
#(
    parameter int ADDR_W = AEOLUS_ADDR_W,
    parameter int DATA_W = AEOLUS_DATA_W
) (
    input  logic              boardCLK,
    input  logic              reset,
    input  logic              ifReq,
    input  logic [ADDR_W-1:0] ifAddr,
    output logic              ifGnt,
    output logic              ifValid,
    output logic [DATA_W-1:0] ifRdata,
    input  logic              dReq,
    input  logic              dWe,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [DATA_W-1:0] dWdata,
    output logic              dGnt,
    output logic              dValid,
    output logic [DATA_W-1:0] dRdata,
    output logic              memEn,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic [DATA_W-1:0] memRdata
`ifdef AEOLUS_ARB_STATS_EN
    ,
    output logic [15:0]       conflictCount
`endif
);

    logic              r_if_gnt;
    logic              r_d_gnt;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_last_gnt;
    owner_e            r_owner;
    logic              r_if_valid;
    logic              r_d_valid;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic [1:0]        w_eff_req;
    logic [1:0]        w_win;
    logic              w_any_win;

    // A master granted this cycle is masked so a held req is treated as a
    // fresh request only after its grant cycle has passed.
    assign w_eff_req = {dReq & ~r_d_gnt, ifReq & ~r_if_gnt};
    assign w_any_win = |w_win;

    rr_arb2 u_rr_arb2 (
        .effReq  (w_eff_req),
        .lastGnt (r_last_gnt),
        .win     (w_win)
    );

    always_ff @(posedge boardCLK or posedge reset) begin
        if (reset) begin
            r_if_gnt    <= 1'b0;
            r_d_gnt     <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_last_gnt  <= c_GNT_DATA;
            r_owner     <= OWNER_NONE;
            r_if_valid  <= 1'b0;
            r_d_valid   <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_if_gnt <= w_win[0];
            r_d_gnt  <= w_win[1];
            r_mem_en <= w_any_win;
            r_mem_we <= w_win[1] & dWe;

            // Address/write data hold their last values on idle cycles.
            if (w_win[0]) begin
                r_mem_addr <= ifAddr;
            end else if (w_win[1]) begin
                r_mem_addr  <= dAddr;
                r_mem_wdata <= dWdata;
            end

            if (w_any_win) begin
                r_last_gnt <= w_win[1] ? c_GNT_DATA : c_GNT_IF;
            end

            // Owner tracks the read issued this cycle; writes return nothing.
            if (w_win[0]) begin
                r_owner <= OWNER_IF;
            end else if (w_win[1] && !dWe) begin
                r_owner <= OWNER_DATA;
            end else begin
                r_owner <= OWNER_NONE;
            end

            r_if_valid <= (r_owner == OWNER_IF);
            r_d_valid  <= (r_owner == OWNER_DATA);

            // Capture returned data so each port holds it once valid drops.
            if (r_if_valid) begin
                r_if_rdata <= memRdata;
            end
            if (r_d_valid) begin
                r_d_rdata <= memRdata;
            end
        end
    end

    assign ifGnt    = r_if_gnt;
    assign dGnt     = r_d_gnt;
    assign memEn    = r_mem_en;
    assign memWe    = r_mem_we;
    assign memAddr  = r_mem_addr;
    assign memWdata = r_mem_wdata;
    assign ifValid  = r_if_valid;
    assign dValid   = r_d_valid;
    // RAM data arrives in the valid cycle itself, so it bypasses the hold
    // register while valid is high.
    assign ifRdata  = r_if_valid ? memRdata : r_if_rdata;
    assign dRdata   = r_d_valid  ? memRdata : r_d_rdata;

`ifdef AEOLUS_ARB_STATS_EN
    logic [15:0] r_conflict_count;

    always_ff @(posedge boardCLK or posedge reset) begin
        if (reset) begin
            r_conflict_count <= '0;
        end else if ((&w_eff_req) && (r_conflict_count != 16'hFFFF)) begin
            r_conflict_count <= r_conflict_count + 16'd1;
        end
    end

    assign conflictCount = r_conflict_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aeolus_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_aeolus_mem_arbiter
// Description : Self-checking bench for aeolus_mem_arbiter: directed vector
//               table, hand-written multi-cycle sequences, and randomized
//               traffic against a transaction-level reference model with a
//               RAM model attached to the memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aeolus_mem_arbiter;

    logic       boardCLK = 1'b0;
    logic       reset;
    logic       ifReq;
    logic [7:0] ifAddr;
    logic       ifGnt, ifValid;
    logic [7:0] ifRdata;
    logic       dReq, dWe;
    logic [7:0] dAddr, dWdata;
    logic       dGnt, dValid;
    logic [7:0] dRdata;
    logic       memEn, memWe;
    logic [7:0] memAddr, memWdata;
    logic [7:0] memRdata;
`ifdef AEOLUS_ARB_STATS_EN
    logic [15:0] conflictCount;
    logic [15:0] m_conf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    aeolus_mem_arbiter dut (
        .boardCLK (boardCLK),
        .reset    (reset),
        .ifReq    (ifReq),
        .ifAddr   (ifAddr),
        .ifGnt    (ifGnt),
        .ifValid  (ifValid),
        .ifRdata  (ifRdata),
        .dReq     (dReq),
        .dWe      (dWe),
        .dAddr    (dAddr),
        .dWdata   (dWdata),
        .dGnt     (dGnt),
        .dValid   (dValid),
        .dRdata   (dRdata),
        .memEn    (memEn),
        .memWe    (memWe),
        .memAddr  (memAddr),
        .memWdata (memWdata),
        .memRdata (memRdata)
`ifdef AEOLUS_ARB_STATS_EN
        ,
        .conflictCount (conflictCount)
`endif
    );

    always #5 boardCLK = ~boardCLK;

    // Synchronous single-port RAM: read data one cycle after the strobe.
    logic [7:0] ram [256];
    always @(posedge boardCLK) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'h5A;
            ram[8'h10] <= 8'hA5;
            memRdata   <= 8'h00;
        end else if (memEn) begin
            if (memWe) ram[memAddr] <= memWdata;
            else       memRdata     <= ram[memAddr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    logic       m_if_gnt, m_d_gnt, m_en, m_we, m_last_d;
    logic [7:0] m_addr, m_wdata;
    logic       m_if_valid, m_d_valid;
    logic [7:0] m_if_rdata, m_d_rdata;
    logic [7:0] mram [256];

    task automatic model_reset();
        m_if_gnt = 0; m_d_gnt = 0; m_en = 0; m_we = 0; m_last_d = 1;
        m_addr = 0; m_wdata = 0; m_if_valid = 0; m_d_valid = 0;
        m_if_rdata = 0; m_d_rdata = 0;
        for (int i = 0; i < 256; i++) mram[i] = 8'(i) ^ 8'h5A;
        mram[8'h10] = 8'hA5;
`ifdef AEOLUS_ARB_STATS_EN
        m_conf = 0;
`endif
    endtask

    // Advance one clock: complete the access of the current cycle, then
    // decide who is granted next from the requests now on the inputs.
    task automatic model_advance();
        logic nv_if, nv_d, eff_if, eff_d, win_if, win_d;
        logic [7:0] rd;
        nv_if = m_en && !m_we && m_if_gnt;
        nv_d  = m_en && !m_we && m_d_gnt;
        rd    = mram[m_addr];
        if (m_en && m_we) mram[m_addr] = m_wdata;
        eff_if = ifReq && !m_if_gnt;
        eff_d  = dReq && !m_d_gnt;
`ifdef AEOLUS_ARB_STATS_EN
        if (eff_if && eff_d && m_conf != 16'hFFFF) m_conf = m_conf + 16'd1;
`endif
        win_if = eff_if && (!eff_d || m_last_d);
        win_d  = eff_d && !win_if;
        m_if_valid = nv_if;
        if (nv_if) m_if_rdata = rd;
        m_d_valid = nv_d;
        if (nv_d) m_d_rdata = rd;
        m_if_gnt = win_if;
        m_d_gnt  = win_d;
        m_en     = win_if || win_d;
        m_we     = win_d && dWe;
        if (win_if) m_addr = ifAddr;
        else if (win_d) begin
            m_addr  = dAddr;
            m_wdata = dWdata;
        end
        if (m_en) m_last_d = win_d;
    endtask

    task automatic check_model();
        check("m_ifGnt",    32'(ifGnt),    32'(m_if_gnt));
        check("m_dGnt",     32'(dGnt),     32'(m_d_gnt));
        check("m_memEn",    32'(memEn),    32'(m_en));
        check("m_memWe",    32'(memWe),    32'(m_we));
        check("m_memAddr",  32'(memAddr),  32'(m_addr));
        check("m_memWdata", 32'(memWdata), 32'(m_wdata));
        check("m_ifValid",  32'(ifValid),  32'(m_if_valid));
        check("m_dValid",   32'(dValid),   32'(m_d_valid));
        check("m_ifRdata",  32'(ifRdata),  32'(m_if_rdata));
        check("m_dRdata",   32'(dRdata),   32'(m_d_rdata));
`ifdef AEOLUS_ARB_STATS_EN
        check("m_conflictCount", 32'(conflictCount), 32'(m_conf));
`endif
    endtask

    // Called at a falling edge: drive inputs, step model, check next cycle.
    task automatic step(input logic ir, input logic [7:0] ia, input logic dr,
                        input logic dw, input logic [7:0] da, input logic [7:0] dd);
        ifReq = ir; ifAddr = ia; dReq = dr; dWe = dw; dAddr = da; dWdata = dd;
        model_advance();
        @(negedge boardCLK);
        check_model();
    endtask

    task automatic idle(input int n);
        ifReq = 0; dReq = 0; dWe = 0;
        repeat (n) @(negedge boardCLK);
    endtask

    task automatic pulse_reset();
        reset = 1;
        @(negedge boardCLK);
        @(negedge boardCLK);
        reset = 0;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       if_req;  logic [7:0] if_addr;
        logic       d_req;   logic d_we; logic [7:0] d_addr; logic [7:0] d_wdata;
        logic       e_if_gnt; logic e_d_gnt; logic e_en; logic e_we;
        logic [7:0] e_addr;  logic [7:0] e_wdata;
        logic       e_if_valid; logic e_d_valid;
        logic [7:0] e_if_rdata; logic [7:0] e_d_rdata;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic       ir, dr, dw;
        logic [7:0] ia, da, dd;

        // fetch read, data write, data read-back, then first conflict
        vecs[0] = '{1, 8'h10, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00};
        vecs[1] = '{0, 8'h10, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h10, 8'h00, 1, 0, 8'hA5, 8'h00};
        vecs[2] = '{0, 8'h00, 1, 1, 8'h20, 8'h3C, 0, 1, 1, 1, 8'h20, 8'h3C, 0, 0, 8'hA5, 8'h00};
        vecs[3] = '{0, 8'h00, 0, 0, 8'h20, 8'h3C, 0, 0, 0, 0, 8'h20, 8'h3C, 0, 0, 8'hA5, 8'h00};
        vecs[4] = '{0, 8'h00, 1, 0, 8'h20, 8'h3C, 0, 1, 1, 0, 8'h20, 8'h3C, 0, 0, 8'hA5, 8'h00};
        vecs[5] = '{0, 8'h00, 0, 0, 8'h20, 8'h3C, 0, 0, 0, 0, 8'h20, 8'h3C, 0, 1, 8'hA5, 8'h3C};
        vecs[6] = '{1, 8'h30, 1, 0, 8'h40, 8'h00, 1, 0, 1, 0, 8'h30, 8'h3C, 0, 0, 8'hA5, 8'h3C};
        vecs[7] = '{0, 8'h30, 1, 0, 8'h40, 8'h00, 0, 1, 1, 0, 8'h40, 8'h00, 1, 0, 8'h6A, 8'h3C};
        vecs[8] = '{0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h40, 8'h00, 0, 1, 8'h6A, 8'h1A};

        reset = 1; ifReq = 0; ifAddr = 0; dReq = 0; dWe = 0; dAddr = 0; dWdata = 0;
        model_reset();
        @(negedge boardCLK);
        @(negedge boardCLK);
        check("rst_ifGnt",   32'(ifGnt),   0);
        check("rst_dGnt",    32'(dGnt),    0);
        check("rst_memEn",   32'(memEn),   0);
        check("rst_memWe",   32'(memWe),   0);
        check("rst_memAddr", 32'(memAddr), 0);
        check("rst_memWdata",32'(memWdata),0);
        check("rst_ifValid", 32'(ifValid), 0);
        check("rst_dValid",  32'(dValid),  0);
        check("rst_ifRdata", 32'(ifRdata), 0);
        check("rst_dRdata",  32'(dRdata),  0);
        reset = 0;

        for (int k = 0; k < 9; k++) begin
            ifReq = vecs[k].if_req; ifAddr = vecs[k].if_addr;
            dReq = vecs[k].d_req; dWe = vecs[k].d_we; dAddr = vecs[k].d_addr; dWdata = vecs[k].d_wdata;
            @(negedge boardCLK);
            check($sformatf("v%0d_ifGnt", k),    32'(ifGnt),    32'(vecs[k].e_if_gnt));
            check($sformatf("v%0d_dGnt", k),     32'(dGnt),     32'(vecs[k].e_d_gnt));
            check($sformatf("v%0d_memEn", k),    32'(memEn),    32'(vecs[k].e_en));
            check($sformatf("v%0d_memWe", k),    32'(memWe),    32'(vecs[k].e_we));
            check($sformatf("v%0d_memAddr", k),  32'(memAddr),  32'(vecs[k].e_addr));
            check($sformatf("v%0d_memWdata", k), 32'(memWdata), 32'(vecs[k].e_wdata));
            check($sformatf("v%0d_ifValid", k),  32'(ifValid),  32'(vecs[k].e_if_valid));
            check($sformatf("v%0d_dValid", k),   32'(dValid),   32'(vecs[k].e_d_valid));
            check($sformatf("v%0d_ifRdata", k),  32'(ifRdata),  32'(vecs[k].e_if_rdata));
            check($sformatf("v%0d_dRdata", k),   32'(dRdata),   32'(vecs[k].e_d_rdata));
        end

        // Both held: IF, D, IF, D ... with reads routed one cycle later.
        ifReq = 1; ifAddr = 8'h50; dReq = 1; dWe = 0; dAddr = 8'h60; dWdata = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge boardCLK);
            check($sformatf("alt%0d_ifGnt", i),   32'(ifGnt),   32'(i % 2 == 0));
            check($sformatf("alt%0d_dGnt", i),    32'(dGnt),    32'(i % 2 == 1));
            check($sformatf("alt%0d_ifValid", i), 32'(ifValid), 32'(i % 2 == 1));
            check($sformatf("alt%0d_dValid", i),  32'(dValid),  32'(i > 0 && i % 2 == 0));
            if (i >= 1) check($sformatf("alt%0d_ifRdata", i), 32'(ifRdata), 32'h0A);
            if (i >= 2) check($sformatf("alt%0d_dRdata", i),  32'(dRdata),  32'h3A);
        end
        idle(3);

        // Reset during an in-flight fetch read.
        ifReq = 1; ifAddr = 8'h10;
        @(negedge boardCLK);
        check("mr_ifGnt", 32'(ifGnt), 1);
        ifReq = 0;
        reset = 1;
        #1;
        check("mr_async_ifGnt",   32'(ifGnt),   0);
        check("mr_async_memEn",   32'(memEn),   0);
        check("mr_async_memAddr", 32'(memAddr), 0);
        check("mr_async_ifRdata", 32'(ifRdata), 0);
        check("mr_async_dRdata",  32'(dRdata),  0);
        for (int i = 0; i < 2; i++) begin
            @(negedge boardCLK);
            check("mr_ifValid", 32'(ifValid), 0);
            check("mr_memWdata", 32'(memWdata), 0);
        end
        reset = 0;
        ifReq = 1; dReq = 1; dWe = 0; ifAddr = 8'h11; dAddr = 8'h22;
        @(negedge boardCLK);
        check("mr_first_ifGnt", 32'(ifGnt), 1);
        check("mr_first_dGnt",  32'(dGnt),  0);
        check("mr_no_ifValid",  32'(ifValid), 0);
        idle(3);

        // Randomized traffic honouring the requester protocol.
        pulse_reset();
        ifReq = 0; dReq = 0; dWe = 0;
        for (int n = 0; n < 400; n++) begin
            if (ifReq && !m_if_gnt && ($urandom % 8) != 0) begin
                ir = 1; ia = ifAddr;
            end else begin
                ir = 1'($urandom % 2); ia = 8'($urandom);
            end
            if (dReq && !m_d_gnt && ($urandom % 8) != 0) begin
                dr = 1; dw = dWe; da = dAddr; dd = dWdata;
            end else begin
                dr = 1'($urandom % 2); dw = 1'($urandom % 2); da = 8'($urandom); dd = 8'($urandom);
            end
            step(ir, ia, dr, dw, da, dd);
        end
        idle(2);

`ifdef AEOLUS_ARB_STATS_EN
        // Both held for 10 cycles.
        pulse_reset();
        for (int i = 0; i < 10; i++) step(1, 8'h01, 1, 0, 8'h02, 8'h00);
        check("stats_hold", 32'(conflictCount), 32'(m_conf));
        step(0, 8'h00, 0, 0, 8'h00, 8'h00);
        step(0, 8'h00, 0, 0, 8'h00, 8'h00);

        // Saturation from a preloaded near-full count.
        force dut.r_conflict_count = 16'hFFFE;
        #1;
        release dut.r_conflict_count;
        m_conf = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            step(1, 8'h03, 1, 0, 8'h04, 8'h00);
            step(0, 8'h03, 1, 0, 8'h04, 8'h00);
            step(0, 8'h00, 0, 0, 8'h00, 8'h00);
        end
        check("stats_sat", 32'(conflictCount), 32'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
